// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronised rising edges of one selected
// oscillator over a programmable window, for a single channel or a sweep of all channels.
module ro_freq_meter #(
  parameter int NUM_RO = 16,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 24,
  parameter int WIN_W  = 16,
  parameter int SETTLE = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic [NUM_RO-1:0] ro_in,
  input  logic [SEL_W-1:0]  ro_sel,
  input  logic              sweep,
  input  logic [WIN_W-1:0]  win_len,
  input  logic              start,
  output logic              ro_start,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_cnt,
  output logic [SEL_W-1:0]  res_ch,
  output logic              res_ovf,
  output logic              done
);

  localparam int STW = $clog2(SETTLE + 1);
  localparam int TW  = (WIN_W > STW) ? WIN_W : STW;
  localparam logic [TW-1:0]    SETTLE_LD = TW'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_RO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_MEAS, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             sweep_q, sweep_d;
  logic [SEL_W-1:0] ch_q, ch_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             sync1_q, sync2_q, dly_q;
  logic             sel_bit, rise;

  // Out-of-range channel indices match no input and read as 0.
  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < NUM_RO; i++) begin
      if (ch_q == SEL_W'(i)) sel_bit = ro_in[i];
    end
  end

  // ch is stable through SETTLE, so SETTLE >= 3 cycles refills all three flops.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= sel_bit;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign rise = sync2_q & ~dly_q;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    win_d   = win_q;
    sweep_d = sweep_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // done_q blocks a start presented in the same cycle as the done pulse.
        if (start && !done_q) begin
          state_d = S_SETTLE;
          tmr_d   = SETTLE_LD;
          sweep_d = sweep;
          win_d   = (win_len == '0) ? WIN_W'(1) : win_len;
          ch_d    = sweep ? '0 : ro_sel;
        end
      end
      S_SETTLE: begin
        cnt_d = '0;
        ovf_d = 1'b0;
        if (tmr_q == '0) begin
          state_d = S_MEAS;
          tmr_d   = TW'(win_q) - TW'(1);
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_MEAS: begin
        if (rise) begin
          if (cnt_q == CNT_MAX) ovf_d = 1'b1;
          else                  cnt_d = cnt_q + CNT_W'(1);
        end
        if (tmr_q == '0) state_d = S_HOLD;
        else             tmr_d   = tmr_q - TW'(1);
      end
      S_HOLD: begin
        if (res_ready) begin
          if (sweep_q && (ch_q < LAST_CH)) begin
            ch_d    = ch_q + SEL_W'(1);
            state_d = S_SETTLE;
            tmr_d   = SETTLE_LD;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      win_q   <= '0;
      sweep_q <= 1'b0;
      ch_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      win_q   <= win_d;
      sweep_q <= sweep_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign ro_start  = (state_q == S_SETTLE) || (state_q == S_MEAS);
  assign res_valid = (state_q == S_HOLD);
  assign res_cnt   = cnt_q;
  assign res_ch    = ch_q;
  assign res_ovf   = ovf_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ro_freq_meter.sv
// Bench for ro_freq_meter: synchronous square-wave oscillators with random phase,
// table vectors, randomized runs against a count model, sweep, stall and reset sequences.
module tb_ro_freq_meter;
  localparam int NUM_RO = 5;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 6;
  localparam int WIN_W  = 10;
  localparam int SETTLE = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_ni = 1'b0;
  logic [NUM_RO-1:0] ro_in;
  logic [SEL_W-1:0]  ro_sel = '0;
  logic              sweep = 1'b0;
  logic [WIN_W-1:0]  win_len = '0;
  logic              start = 1'b0;
  logic              res_ready = 1'b0;
  logic              ro_start, busy, res_valid, res_ovf, done;
  logic [CNT_W-1:0]  res_cnt;
  logic [SEL_W-1:0]  res_ch;

  int checks = 0;
  int failures = 0;
  int per[NUM_RO];
  int ph[NUM_RO];
  logic cval[NUM_RO];

  typedef struct {
    int sel; int win; int psel; int poth; int cv; int rdy; int exp_cnt; int exp_ovf;
  } vec_t;

  ro_freq_meter #(
    .NUM_RO(NUM_RO), .SEL_W(SEL_W), .CNT_W(CNT_W), .WIN_W(WIN_W), .SETTLE(SETTLE)
  ) u_dut (
    .wb_clk_i (wb_clk_i),  .wb_rst_ni(wb_rst_ni), .ro_in(ro_in),   .ro_sel(ro_sel),
    .sweep    (sweep),     .win_len  (win_len),   .start(start),   .ro_start(ro_start),
    .busy     (busy),      .res_valid(res_valid), .res_ready(res_ready),
    .res_cnt  (res_cnt),   .res_ch   (res_ch),    .res_ovf(res_ovf), .done(done)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Period 0 means a constant level; otherwise one rising edge per period.
  always @(negedge wb_clk_i) begin
    for (int k = 0; k < NUM_RO; k++) begin
      if (per[k] == 0) ro_in[k] = cval[k];
      else begin
        ph[k] = (ph[k] + 1) % per[k];
        ro_in[k] = (ph[k] < per[k] / 2);
      end
    end
  end

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, got, lo, hi);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".ro_start"}, ro_start, 0);
    chk({nm, ".busy"}, busy, 0);
    chk({nm, ".res_valid"}, res_valid, 0);
    chk({nm, ".res_ovf"}, res_ovf, 0);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".res_cnt"}, res_cnt, 0);
    chk({nm, ".res_ch"}, res_ch, 0);
  endtask

  task automatic set_chan(input int k, input int p, input int cv);
    per[k]  = p;
    cval[k] = cv[0];
    ph[k]   = (p > 0) ? int'($urandom_range(p - 1, 0)) : 0;
  endtask

  // Reference: a window of w consecutive samples of a period-p wave holds
  // floor(w/p) or ceil(w/p) rising edges; the counter then saturates at CMAX.
  task automatic model(input int p, input int w, output int lo, output int hi,
                       output int olo, output int ohi);
    int we, nlo, nhi;
    we = (w == 0) ? 1 : w;
    if (p == 0) begin nlo = 0; nhi = 0; end
    else begin nlo = we / p; nhi = (we + p - 1) / p; end
    lo  = (nlo > CMAX) ? CMAX : nlo;
    hi  = (nhi > CMAX) ? CMAX : nhi;
    olo = (nlo > CMAX) ? 1 : 0;
    ohi = (nhi > CMAX) ? 1 : 0;
  endtask

  task automatic run_one(input string nm, input int sel, input int win, input int rdy_dly,
                         input int lo, input int hi, input int olo, input int ohi);
    int lat, c, ch, ov, ok;
    ro_sel = sel[SEL_W-1:0]; sweep = 1'b0; win_len = win[WIN_W-1:0]; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 1;
    chk({nm, ".accept"}, busy, 1);
    while (!res_valid && lat < 3000) begin tick; lat++; end
    chk({nm, ".latency"}, lat, SETTLE + ((win == 0) ? 1 : win) + 1);
    c = res_cnt; ch = res_ch; ov = res_ovf;
    chk_rng({nm, ".cnt"}, c, lo, hi);
    chk({nm, ".ch"}, ch, sel);
    chk_rng({nm, ".ovf"}, ov, olo, ohi);
    chk({nm, ".ro_start_hold"}, ro_start, 0);
    ok = 1;
    for (int i = 0; i < rdy_dly; i++) begin
      start = (i == 5);
      tick;
      if (!res_valid || res_cnt != c[CNT_W-1:0] || res_ch != ch[SEL_W-1:0] ||
          res_ovf != ov[0] || ro_start || !busy || done) ok = 0;
    end
    start = 1'b0;
    if (rdy_dly > 0) chk({nm, ".hold_stable"}, ok, 1);
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    chk({nm, ".done"}, done, 1);
    chk({nm, ".idle"}, busy, 0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk({nm, ".start_at_done_ignored"}, busy, 0);
    chk({nm, ".done_one_cycle"}, done, 0);
  endtask

  initial begin
    vec_t tbl[8];
    int lo, hi, olo, ohi, sel, win, n, nd, cyc, first, seen;
    int got_ch[NUM_RO];
    int got_cnt[NUM_RO];

    for (int k = 0; k < NUM_RO; k++) set_chan(k, 0, 0);
    repeat (3) tick;
    chk_zero("reset");
    wb_rst_ni = 1'b1;
    tick;
    chk("post_reset.busy", busy, 0);

    //          sel win  psel poth cv rdy cnt ovf
    tbl[0] = '{3, 100, 10, 7, 0, 2,  10, 0};
    tbl[1] = '{1, 0,   0,  5, 1, 0,  0,  0};
    tbl[2] = '{2, 400, 4,  9, 0, 1,  63, 1};
    tbl[3] = '{6, 100, 0,  4, 0, 0,  0,  0};
    tbl[4] = '{0, 50,  5,  7, 0, 0,  10, 0};
    tbl[5] = '{4, 300, 6,  4, 0, 20, 50, 0};
    tbl[6] = '{2, 252, 4,  9, 0, 0,  63, 0};
    tbl[7] = '{2, 256, 4,  9, 0, 3,  63, 1};
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < NUM_RO; k++)
        set_chan(k, (k == tbl[i].sel) ? tbl[i].psel : tbl[i].poth,
                 (k == tbl[i].sel) ? tbl[i].cv : 0);
      run_one($sformatf("vec%0d", i), tbl[i].sel, tbl[i].win, tbl[i].rdy,
              tbl[i].exp_cnt, tbl[i].exp_cnt, tbl[i].exp_ovf, tbl[i].exp_ovf);
    end

    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < NUM_RO; k++) set_chan(k, int'($urandom_range(20, 4)), 0);
      sel = int'($urandom_range(7, 0));
      win = int'($urandom_range(300, 0));
      model((sel < NUM_RO) ? per[sel] : 0, win, lo, hi, olo, ohi);
      run_one($sformatf("rand%0d", r), sel, win, int'($urandom_range(3, 0)), lo, hi, olo, ohi);
    end

    // Sweep with res_ready tied high: one result per channel, then one done.
    for (int k = 0; k < NUM_RO; k++) set_chan(k, 4 + 2 * k, 0);
    res_ready = 1'b1; sweep = 1'b1; win_len = 10'd240; start = 1'b1;
    tick;
    start = 1'b0;
    n = 0; nd = 0; cyc = 1; first = 0;
    while (nd == 0 && cyc < 5000) begin
      if (res_valid) begin
        if (n < NUM_RO) begin got_ch[n] = res_ch; got_cnt[n] = res_cnt; end
        if (n == 0) first = cyc;
        n++;
      end
      if (done) nd++;
      tick;
      cyc++;
    end
    repeat (4) begin if (done) nd++; tick; end
    res_ready = 1'b0; sweep = 1'b0;
    chk("sweep.first_latency", first, SETTLE + 240 + 1);
    chk("sweep.results", n, NUM_RO);
    chk("sweep.done_pulses", nd, 1);
    for (int k = 0; k < NUM_RO; k++) begin
      chk($sformatf("sweep.ch%0d", k), got_ch[k], k);
      chk($sformatf("sweep.cnt%0d", k), got_cnt[k], 240 / (4 + 2 * k));
    end

    // Asynchronous reset in the middle of a measurement window.
    for (int k = 0; k < NUM_RO; k++) set_chan(k, 4, 0);
    ro_sel = 3'd2; win_len = 10'd200; start = 1'b1;
    tick;
    start = 1'b0;
    repeat (SETTLE + 20) tick;
    chk("abort.in_meas", ro_start, 1);
    #2 wb_rst_ni = 1'b0;
    #1 chk_zero("abort");
    tick;
    tick;
    wb_rst_ni = 1'b1;
    seen = 0;
    repeat (250) begin tick; if (res_valid || done || busy) seen = 1; end
    chk("abort.no_result", seen, 0);
    run_one("after_abort", 2, 40, 0, 10, 10, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_freq_meter.md
RO_FREQ_METER -- requirements
Module: ro_freq_meter

Interface
REQ-001 SHALL have parameter NUM_RO, default 16: number of ring-oscillator channels, range 2..64.
REQ-002 SHALL have parameter SEL_W, default 4: channel index width, equal to clog2(NUM_RO).
REQ-003 SHALL have parameter CNT_W, default 24: edge-counter width.
REQ-004 SHALL have parameter WIN_W, default 16: measurement-window length width.
REQ-005 SHALL have parameter SETTLE, default 8: oscillator settle time in clocks, minimum 3.
REQ-006 SHALL have port wb_clk_i  in  1  sole clock; one clock, reset is asynchronous and active-low.
REQ-007 SHALL have port wb_rst_ni  in  1  asynchronous active-low reset.
REQ-008 SHALL have port ro_in  in  NUM_RO  oscillator outputs, asynchronous to wb_clk_i.
REQ-009 SHALL have port ro_sel  in  SEL_W  channel used in single mode.
REQ-010 SHALL have port sweep  in  1  mode select: 0 = single channel, 1 = all channels 0..NUM_RO-1.
REQ-011 SHALL have port win_len  in  WIN_W  measurement window in clocks.
REQ-012 SHALL have port start  in  1  run request.
REQ-013 SHALL have port ro_start  out  1  enable driven to all oscillators.
REQ-014 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-015 SHALL have ports res_valid out 1, res_ready in 1, res_cnt out CNT_W, res_ch out SEL_W and res_ovf out 1, forming the result handshake.
REQ-016 SHALL have port done  out  1  one-cycle pulse at the end of a run.

Function
REQ-017 SHALL implement the states IDLE, SETTLE, MEAS and HOLD.
REQ-018 SHALL accept start only in IDLE; start SHALL be ignored in every other state.
REQ-019 On acceptance SHALL latch sweep and win_len, and SHALL set ch = sweep ? 0 : ro_sel.
REQ-020 SHALL treat win_len = 0 as 1.
REQ-021 SHALL go IDLE -> SETTLE on an accepted start.
REQ-022 SETTLE SHALL last exactly SETTLE cycles, clearing the counter and res_ovf and flushing the synchroniser.
REQ-023 SHALL go SETTLE -> MEAS, and MEAS SHALL last exactly the latched window (win_len) cycles.
REQ-024 ro_start SHALL be 1 in SETTLE and MEAS and 0 in IDLE and HOLD.
REQ-025 SHALL pass the selected channel ro_in[ch] through a 2-flop synchroniser followed by a rising-edge detect flop.
REQ-026 SHALL add 1 to the counter for each rising edge detected during a MEAS cycle, and SHALL not count edges detected outside MEAS.
REQ-027 The counter SHALL saturate at 2^CNT_W-1, and res_ovf SHALL be set if any edge occurs while the counter is saturated.
REQ-028 If ch >= NUM_RO, the selected input SHALL read as 0 and the result SHALL be res_cnt = 0.
REQ-029 SHALL go MEAS -> HOLD, asserting res_valid and driving res_cnt, res_ch = ch and res_ovf, all held stable until res_valid && res_ready.
REQ-030 On transfer with sweep = 1 and ch < NUM_RO-1, SHALL set ch = ch+1 and go to SETTLE.
REQ-031 On transfer in any other case, SHALL go to IDLE and pulse done for one cycle, coincident with entering IDLE.
REQ-032 If res_ready is high on the first HOLD cycle, the transfer SHALL complete in that cycle.
REQ-033 The first res_valid SHALL occur SETTLE + win_len + 1 clocks after the start-accept edge.
REQ-034 Edges faster than wb_clk_i/2 are out of range and their count is undefined; no other behaviour SHALL be affected.
REQ-035 A new start asserted in the same cycle that done pulses SHALL be ignored; start is accepted from the next cycle.

Reset
REQ-036 wb_rst_ni low SHALL asynchronously force IDLE.
REQ-037 During reset, ro_start, busy, res_valid, res_ovf and done SHALL be 0.
REQ-038 During reset, res_cnt, res_ch, the counter, ch and the synchroniser flops SHALL be 0.
REQ-039 Reset asserted mid-run SHALL abort the run with no result or done emitted; the block SHALL leave reset synchronously on the first clock edge after deassertion.

Verification
REQ-040 Single mode, ro_sel=3, ro_in[3] toggling at clk/10, win_len=100, SETTLE=8 -> res_valid at cycle 109, res_cnt=10 (+/-1), res_ch=3, res_ovf=0, done 1 cycle after the handshake.
REQ-041 Sweep mode, NUM_RO=4, channel k toggling at clk/(4+2k), win_len=240, res_ready tied 1 -> 4 results with res_ch 0,1,2,3 and counts 60,40,30,24 (+/-1), then one done pulse.
REQ-042 CNT_W=4, ro_in toggling at clk/4, win_len=200 -> res_cnt=15, res_ovf=1.
REQ-043 res_ready held 0 for 20 cycles in HOLD, then start pulsed -> res_* stable, start ignored, ro_start=0 until release.
REQ-044 wb_rst_ni pulsed low mid-MEAS -> all outputs 0 immediately, no res_valid/done; a new start then runs normally.
REQ-045 win_len=0, constant ro_in -> res_valid at SETTLE+2, res_cnt=0.
